// File: rtl/usb_tx_sched_pkg.sv
// Shared types and helpers for the USB TX byte-stream scheduler.
package usb_tx_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } requester_t;

    // Width of the idle timer.
    // It must be wide enough to hold the full FORCE_DELAY load value.
    function automatic int timer_width(input int delay);
        return $clog2(delay + 1);
    endfunction

endpackage

// File: rtl/usb_rr_arbiter2.sv
// Two-way round-robin arbiter.
// A lone requester always wins. On a tie, the requester that did not win
// last time is chosen.
module usb_rr_arbiter2
    import usb_tx_sched_pkg::*;
(
    input  logic [1:0] req_i,
    input  requester_t last_owner_i,
    output requester_t winner_o,
    output logic       valid_o
);

    // Pick the winner from the current request pattern and the previous owner
    always_comb begin
        valid_o  = |req_i;
        winner_o = REQ_CPU;
        if (req_i == 2'b11) begin
            winner_o = (last_owner_i == REQ_CPU) ? REQ_DMA : REQ_CPU;
        end else if (req_i[1]) begin
            winner_o = REQ_DMA;
        end
    end

endmodule

// File: rtl/usb_tx_scheduler.sv
// USB TX scheduler.
// Shares the FT1248 TX FIFO write port between the CPU and the DMA, one
// declared-length burst at a time. After the stream has been idle for
// FORCE_DELAY cycles following a burst, it emits a single tx_force pulse so
// that short packets are sent.
module usb_tx_scheduler
    import usb_tx_sched_pkg::*;
#(
    parameter int LEN_WIDTH   = 16,
    parameter int FORCE_DELAY = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           req,
    input  logic [LEN_WIDTH-1:0] len0,
    input  logic [LEN_WIDTH-1:0] len1,
    output logic [1:0]           gnt,
    input  logic [1:0]           wr,
    input  logic [7:0]           wdata0,
    input  logic [7:0]           wdata1,
    output logic [1:0]           ready,
    input  logic                 tx_full,
    output logic                 tx_write,
    output logic [7:0]           tx_wdata,
    output logic                 tx_force,
    output logic [LEN_WIDTH-1:0] remaining,
    output logic                 busy,
    output logic                 err_sticky
);

    localparam int                 TIMER_W    = timer_width(FORCE_DELAY);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(FORCE_DELAY);

    state_t               state_q, state_d;
    logic [1:0]           gnt_q, gnt_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    requester_t           last_q, last_d;
    logic                 err_q, err_d;
    logic                 force_q, force_d;

    requester_t arb_winner;
    logic       arb_valid;
    logic       owner_wr;
    logic [7:0] owner_data;
    logic       accept;

    usb_rr_arbiter2 u_arb (
        .req_i        (req),
        .last_owner_i (last_q),
        .winner_o     (arb_winner),
        .valid_o      (arb_valid)
    );

    // Owner byte path.
    // The owner's strobe and data reach the FIFO in the same cycle.
    // A zero-length grant never moves a byte.
    always_comb begin
        owner_wr   = gnt_q[1] ? wr[1] : wr[0];
        owner_data = gnt_q[1] ? wdata1 : wdata0;
        accept     = (state_q == S_ACTIVE) && owner_wr && !tx_full && (rem_q != '0);
        tx_write   = accept;
        tx_wdata   = (state_q == S_ACTIVE) ? owner_data : 8'h00;
        ready      = gnt_q & {2{~tx_full}};
    end

    // Burst sequencing.
    // A request arriving during drain preempts the pending force pulse.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rem_d   = rem_q;
        timer_d = timer_q;
        last_d  = last_q;
        force_d = 1'b0;
        err_d   = err_q | (|(wr & ~gnt_q));
        case (state_q)
            S_IDLE, S_DRAIN: begin
                if (arb_valid) begin
                    state_d = S_ACTIVE;
                    gnt_d   = (arb_winner == REQ_DMA) ? 2'b10 : 2'b01;
                    rem_d   = (arb_winner == REQ_DMA) ? len1 : len0;
                    last_d  = arb_winner;
                    timer_d = '0;
                end else if (state_q == S_DRAIN) begin
                    if (timer_q <= TIMER_W'(1)) begin
                        timer_d = '0;
                        force_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    rem_d = rem_q - LEN_WIDTH'(1);
                end
                if ((rem_q == '0) || (accept && (rem_q == LEN_WIDTH'(1)))) begin
                    state_d = S_DRAIN;
                    gnt_d   = '0;
                    timer_d = TIMER_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers.
    // Reset clears everything at once and abandons any partial burst.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            rem_q   <= '0;
            timer_q <= '0;
            last_q  <= REQ_DMA;
            err_q   <= 1'b0;
            force_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rem_q   <= rem_d;
            timer_q <= timer_d;
            last_q  <= last_d;
            err_q   <= err_d;
            force_q <= force_d;
        end
    end

    assign gnt        = gnt_q;
    assign remaining  = rem_q;
    assign busy       = (state_q != S_IDLE);
    assign err_sticky = err_q;
    assign tx_force   = force_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Testbench for usb_tx_scheduler: directed scenarios plus randomized traffic
// compared against a burst-level reference model.
module tb_usb_tx_scheduler;

    localparam int LW = 16;
    localparam int FD = 1024;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [1:0]    req = '0;
    logic [LW-1:0] len0 = '0;
    logic [LW-1:0] len1 = '0;
    logic [1:0]    wr = '0;
    logic [7:0]    wdata0 = '0;
    logic [7:0]    wdata1 = '0;
    logic          tx_full = 1'b0;
    logic [1:0]    gnt;
    logic [1:0]    ready;
    logic          tx_write;
    logic [7:0]    tx_wdata;
    logic          tx_force;
    logic [LW-1:0] remaining;
    logic          busy;
    logic          err_sticky;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the stream, bytes still owed, idle cycles since burst end
    int m_owner;
    int m_left;
    int m_last;
    bit m_armed;
    int m_idle;
    bit m_force;
    bit m_err;

    always #5 clk = ~clk;

    usb_tx_scheduler #(.LEN_WIDTH(LW), .FORCE_DELAY(FD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .len0       (len0),
        .len1       (len1),
        .gnt        (gnt),
        .wr         (wr),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ready      (ready),
        .tx_full    (tx_full),
        .tx_write   (tx_write),
        .tx_wdata   (tx_wdata),
        .tx_force   (tx_force),
        .remaining  (remaining),
        .busy       (busy),
        .err_sticky (err_sticky)
    );

    task automatic model_reset();
        m_owner = -1;
        m_left  = 0;
        m_last  = 1;
        m_armed = 0;
        m_idle  = 0;
        m_force = 0;
        m_err   = 0;
    endtask

    task automatic model_step();
        int w;
        bit acc;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_force = 0;
        for (int i = 0; i < 2; i++) begin
            if (wr[i] && (m_owner != i)) m_err = 1;
        end
        if (m_owner >= 0) begin
            acc = wr[m_owner] && !tx_full && (m_left > 0);
            if (acc) m_left = m_left - 1;
            if (m_left == 0) begin
                m_owner = -1;
                m_armed = 1;
                m_idle  = 0;
            end
        end else if (req != 2'b00) begin
            if (req == 2'b11) w = 1 - m_last;
            else              w = req[1] ? 1 : 0;
            m_owner = w;
            m_left  = (w == 1) ? int'(len1) : int'(len0);
            m_last  = w;
            m_armed = 0;
        end else if (m_armed) begin
            m_idle = m_idle + 1;
            if (m_idle == FD) begin
                m_force = 1;
                m_armed = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0; wr = '0; tx_full = 1'b0; len0 = '0; len1 = '0;
        model_reset();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        req = 2'b11; len0 = 16'd5; len1 = 16'd5;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        checks++;
        if ({tx_write, tx_wdata, tx_force} !== 10'd0) begin
            errors++; $display("FAIL reset_tx: got write=%b data=%h force=%b expected 0/00/0", tx_write, tx_wdata, tx_force);
        end
        checks++;
        if (remaining !== '0) begin errors++; $display("FAIL reset_remaining: got %0d expected 0", remaining); end
        checks++;
        if ({busy, err_sticky} !== 2'b00) begin
            errors++; $display("FAIL reset_busy_err: got busy=%b err=%b expected 0/0", busy, err_sticky);
        end
        tick();
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL reset_hold_gnt: got %b expected 00", gnt); end
        do_reset();
    endtask

    task automatic test_cpu_burst();
        int cnt;
        do_reset();
        len0 = 16'd4; req = 2'b01;
        #2;
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL cpu_gnt_latency: got %b expected 00", gnt); end
        tick();
        req = 2'b00;
        #2;
        checks++;
        if (gnt !== 2'b01 || remaining !== 16'd4) begin
            errors++; $display("FAIL cpu_grant: got gnt=%b rem=%0d expected 01/4", gnt, remaining);
        end
        for (int b = 0; b < 4; b++) begin
            wr = 2'b01; wdata0 = 8'hA0 + 8'(b);
            #2;
            checks++;
            if (tx_write !== 1'b1 || tx_wdata !== (8'hA0 + 8'(b))) begin
                errors++; $display("FAIL cpu_byte%0d: got write=%b data=%h expected 1/%h", b, tx_write, tx_wdata, 8'hA0 + 8'(b));
            end
            tick();
        end
        wr = 2'b00;
        #2;
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b1 || remaining !== '0) begin
            errors++; $display("FAIL cpu_release: got gnt=%b busy=%b rem=%0d expected 00/1/0", gnt, busy, remaining);
        end
        cnt = 0;
        while (tx_force !== 1'b1 && cnt < FD + 50) begin
            tick(); #2; cnt++;
        end
        checks++;
        if (cnt != FD) begin errors++; $display("FAIL cpu_force_delay: got %0d cycles expected %0d", cnt, FD); end
        tick(); #2;
        checks++;
        if (tx_force !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL cpu_force_pulse: got force=%b busy=%b expected 0/0", tx_force, busy);
        end
    endtask

    task automatic test_tie();
        do_reset();
        len0 = 16'd2; len1 = 16'd3; req = 2'b11;
        #2;
        tick();
        req = 2'b10;
        #2;
        checks++;
        if (gnt !== 2'b01 || remaining !== 16'd2) begin
            errors++; $display("FAIL tie_first: got gnt=%b rem=%0d expected 01/2", gnt, remaining);
        end
        for (int b = 0; b < 2; b++) begin
            wr = 2'b01; wdata0 = 8'h10 + 8'(b);
            #2;
            checks++;
            if (tx_write !== 1'b1 || tx_wdata !== (8'h10 + 8'(b))) begin
                errors++; $display("FAIL tie_cpu_byte%0d: got write=%b data=%h expected 1/%h", b, tx_write, tx_wdata, 8'h10 + 8'(b));
            end
            tick();
        end
        wr = 2'b00;
        #2;
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL tie_gap: got gnt=%b expected 00", gnt); end
        tick();
        req = 2'b00;
        #2;
        checks++;
        if (gnt !== 2'b10 || remaining !== 16'd3) begin
            errors++; $display("FAIL tie_second: got gnt=%b rem=%0d expected 10/3", gnt, remaining);
        end
        for (int b = 0; b < 3; b++) begin
            wr = 2'b10; wdata1 = 8'h20 + 8'(b);
            #2;
            checks++;
            if (tx_write !== 1'b1 || tx_wdata !== (8'h20 + 8'(b))) begin
                errors++; $display("FAIL tie_dma_byte%0d: got write=%b data=%h expected 1/%h", b, tx_write, tx_wdata, 8'h20 + 8'(b));
            end
            tick();
        end
        wr = 2'b00;
        #2;
        checks++;
        if (gnt !== 2'b00) begin errors++; $display("FAIL tie_end: got gnt=%b expected 00", gnt); end
    endtask

    task automatic test_full();
        do_reset();
        len1 = 16'd3; req = 2'b10;
        #2;
        tick();
        req = 2'b00;
        wr = 2'b10; wdata1 = 8'h31;
        #2;
        checks++;
        if (gnt !== 2'b10 || tx_write !== 1'b1 || tx_wdata !== 8'h31) begin
            errors++; $display("FAIL full_byte0: got gnt=%b write=%b data=%h expected 10/1/31", gnt, tx_write, tx_wdata);
        end
        tick();
        tx_full = 1'b1; wdata1 = 8'h32;
        for (int k = 0; k < 5; k++) begin
            #2;
            checks++;
            if (tx_write !== 1'b0 || ready !== 2'b00 || remaining !== 16'd2) begin
                errors++; $display("FAIL full_stall%0d: got write=%b ready=%b rem=%0d expected 0/00/2", k, tx_write, ready, remaining);
            end
            tick();
        end
        tx_full = 1'b0;
        #2;
        checks++;
        if (tx_write !== 1'b1 || tx_wdata !== 8'h32 || ready !== 2'b10) begin
            errors++; $display("FAIL full_byte1: got write=%b data=%h ready=%b expected 1/32/10", tx_write, tx_wdata, ready);
        end
        tick();
        wdata1 = 8'h33;
        #2;
        checks++;
        if (tx_write !== 1'b1 || tx_wdata !== 8'h33 || remaining !== 16'd1) begin
            errors++; $display("FAIL full_byte2: got write=%b data=%h rem=%0d expected 1/33/1", tx_write, tx_wdata, remaining);
        end
        tick();
        wr = 2'b00;
        #2;
        checks++;
        if (gnt !== 2'b00 || remaining !== '0) begin
            errors++; $display("FAIL full_end: got gnt=%b rem=%0d expected 00/0", gnt, remaining);
        end
    endtask

    task automatic test_err();
        do_reset();
        len1 = 16'd2; req = 2'b10;
        #2;
        tick();
        req = 2'b00; wr = 2'b01; wdata0 = 8'hEE;
        #2;
        checks++;
        if (tx_write !== 1'b0 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL err_intrude: got write=%b err=%b expected 0/0", tx_write, err_sticky);
        end
        tick();
        wr = 2'b00;
        #2;
        checks++;
        if (err_sticky !== 1'b1 || remaining !== 16'd2) begin
            errors++; $display("FAIL err_set: got err=%b rem=%0d expected 1/2", err_sticky, remaining);
        end
        wr = 2'b10; wdata1 = 8'h41;
        tick();
        wdata1 = 8'h42;
        tick();
        wr = 2'b00;
        repeat (3) tick();
        #2;
        checks++;
        if (err_sticky !== 1'b1) begin errors++; $display("FAIL err_sticky_hold: got %b expected 1", err_sticky); end
        do_reset();
        #2;
        checks++;
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clear: got %b expected 0", err_sticky); end
    endtask

    task automatic test_drain_req();
        int cnt;
        bit seen;
        do_reset();
        seen = 0;
        len0 = 16'd1; req = 2'b01;
        #2;
        tick();
        req = 2'b00; wr = 2'b01; wdata0 = 8'h55;
        tick();
        wr = 2'b00;
        repeat (FD - 10) begin
            tick();
            if (tx_force === 1'b1) seen = 1;
        end
        len1 = 16'd0; req = 2'b10;
        #2;
        tick();
        req = 2'b00;
        #2;
        checks++;
        if (gnt !== 2'b10 || remaining !== '0 || tx_write !== 1'b0 || seen) begin
            errors++; $display("FAIL drain_grant: got gnt=%b rem=%0d write=%b early_force=%b expected 10/0/0/0", gnt, remaining, tx_write, seen);
        end
        tick();
        #2;
        checks++;
        if (gnt !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL zero_len_release: got gnt=%b busy=%b expected 00/1", gnt, busy);
        end
        cnt = 0;
        while (tx_force !== 1'b1 && cnt < FD + 50) begin
            tick(); #2; cnt++;
        end
        checks++;
        if (cnt != FD) begin errors++; $display("FAIL drain_force_delay: got %0d cycles expected %0d", cnt, FD); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        seen = 0;
        len0 = 16'd4; req = 2'b01;
        #2;
        tick();
        req = 2'b00; wr = 2'b01; wdata0 = 8'h61;
        tick();
        wdata0 = 8'h62;
        tick();
        wr = 2'b00;
        #2;
        checks++;
        if (remaining !== 16'd2) begin errors++; $display("FAIL mid_setup: got rem=%0d expected 2", remaining); end
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (gnt !== 2'b00 || remaining !== '0 || busy !== 1'b0 || tx_write !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got gnt=%b rem=%0d busy=%b write=%b expected 00/0/0/0", gnt, remaining, busy, tx_write);
        end
        tick();
        reset_n = 1'b1;
        repeat (FD + 20) begin
            tick();
            if (tx_force === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL mid_no_force: got force pulse expected none"); end
    endtask

    task automatic test_random();
        bit [1:0] pend;
        int       dens;
        logic [1:0] e_gnt;
        logic [1:0] e_ready;
        logic       e_write;
        logic [7:0] e_data;
        logic       e_busy;
        do_reset();
        pend = '0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            dens = (cyc < 3000) ? 8 : 700;
            for (int i = 0; i < 2; i++) begin
                if (m_owner == i) pend[i] = 1'b0;
                if (!pend[i] && m_owner != i && $urandom_range(0, dens) == 0) begin
                    pend[i] = 1'b1;
                    if (i == 0) len0 = LW'($urandom_range(0, 5));
                    else        len1 = LW'($urandom_range(0, 5));
                end
            end
            req = pend;
            for (int i = 0; i < 2; i++) begin
                if (m_owner == i) wr[i] = ($urandom_range(0, 3) != 0);
                else              wr[i] = ($urandom_range(0, 199) == 0);
            end
            wdata0  = 8'($urandom);
            wdata1  = 8'($urandom);
            tx_full = ($urandom_range(0, 4) == 0);
            #2;
            e_gnt   = (m_owner < 0) ? 2'b00 : ((m_owner == 1) ? 2'b10 : 2'b01);
            e_ready = tx_full ? 2'b00 : e_gnt;
            e_write = (m_owner >= 0) && wr[m_owner] && !tx_full && (m_left > 0);
            e_data  = (m_owner < 0) ? 8'h00 : ((m_owner == 1) ? wdata1 : wdata0);
            e_busy  = (m_owner >= 0) || m_armed;
            checks++;
            if (gnt !== e_gnt || ready !== e_ready || tx_write !== e_write || tx_wdata !== e_data ||
                remaining !== LW'(m_left) || busy !== e_busy || tx_force !== m_force || err_sticky !== m_err) begin
                errors++;
                $display("FAIL random_cyc%0d: got gnt=%b rdy=%b wr=%b d=%h rem=%0d busy=%b force=%b err=%b expected %b/%b/%b/%h/%0d/%b/%b/%b",
                         cyc, gnt, ready, tx_write, tx_wdata, remaining, busy, tx_force, err_sticky,
                         e_gnt, e_ready, e_write, e_data, m_left, e_busy, m_force, m_err);
            end
            tick();
        end
        req = '0; wr = '0; tx_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_burst();
        test_tie();
        test_full();
        test_err();
        test_drain_req();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
